// File: rtl/alu_pkg.sv
// Shared types for the integer execute unit: op encodings,
// FSM states and op-class helpers.
package alu_pkg;

    typedef enum logic [4:0] {
        ALU_ADD    = 5'd0,
        ALU_SUB    = 5'd1,
        ALU_SLL    = 5'd2,
        ALU_SLT    = 5'd3,
        ALU_SLTU   = 5'd4,
        ALU_XOR    = 5'd5,
        ALU_SRL    = 5'd6,
        ALU_SRA    = 5'd7,
        ALU_OR     = 5'd8,
        ALU_AND    = 5'd9,
        ALU_EQ     = 5'd10,
        ALU_NE     = 5'd11,
        ALU_LT     = 5'd12,
        ALU_GE     = 5'd13,
        ALU_LTU    = 5'd14,
        ALU_GEU    = 5'd15,
        ALU_MUL    = 5'd16,
        ALU_MULH   = 5'd17,
        ALU_MULHSU = 5'd18,
        ALU_MULHU  = 5'd19,
        ALU_DIV    = 5'd20,
        ALU_DIVU   = 5'd21,
        ALU_REM    = 5'd22,
        ALU_REMU   = 5'd23
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_e;

    function automatic logic is_mdu_op(alu_op_e op);
        return (op >= ALU_MUL) && (op <= ALU_REMU);
    endfunction

    function automatic logic is_mul_op(alu_op_e op);
        return (op >= ALU_MUL) && (op <= ALU_MULHU);
    endfunction

endpackage

// File: rtl/mdu_iter.sv
// Iterative 1-bit/cycle shift-add multiplier and restoring divider.
// Operands are converted to magnitudes at start; sign is reapplied on the way out.
module mdu_iter
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_start,
    input  logic            i_step,
    input  alu_op_e         i_op,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic            o_last,
    output logic [XLEN-1:0] o_result
);
    localparam int CW = $clog2(XLEN);

    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_opnd;
    logic [CW-1:0]     r_count;
    logic              r_neg;
    alu_op_e           r_op;

    logic              w_a_sgn;
    logic              w_b_sgn;
    logic              w_start_mul;
    logic              w_mul;
    logic              w_rem;
    logic [XLEN-1:0]   w_ma;
    logic [XLEN-1:0]   w_mb;
    logic [XLEN:0]     w_sum;
    logic [XLEN:0]     w_diff;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_dres;

    assign w_a_sgn = i_a[XLEN-1]
        & (i_op inside {ALU_MULH, ALU_MULHSU, ALU_DIV, ALU_REM});
    assign w_b_sgn = i_b[XLEN-1]
        & (i_op inside {ALU_MULH, ALU_DIV, ALU_REM});
    assign w_ma = w_a_sgn ? -i_a : i_a;
    assign w_mb = w_b_sgn ? -i_b : i_b;
    assign w_start_mul = is_mul_op(i_op);
    assign w_mul = is_mul_op(r_op);
    assign w_rem = r_op inside {ALU_REM, ALU_REMU};

    // Multiply: add multiplicand into the high half, then shift right.
    assign w_sum = {1'b0, r_acc[2*XLEN-1:XLEN]}
        + {1'b0, {XLEN{r_acc[0]}} & r_opnd};
    // Divide: trial-subtract divisor from the left-shifted partial remainder.
    assign w_diff = r_acc[2*XLEN-1:XLEN-1] - {1'b0, r_opnd};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc   <= '0;
            r_opnd  <= '0;
            r_count <= '0;
            r_neg   <= 1'b0;
            r_op    <= ALU_ADD;
        end else if (i_start) begin
            r_count <= '0;
            r_op    <= i_op;
            r_neg   <= (i_op inside {ALU_REM, ALU_REMU})
                ? w_a_sgn : (w_a_sgn ^ w_b_sgn);
            r_opnd  <= w_start_mul ? w_ma : w_mb;
            r_acc   <= {{XLEN{1'b0}}, (w_start_mul ? w_mb : w_ma)};
        end else if (i_step) begin
            r_count <= r_count + CW'(1);
            if (w_mul)
                r_acc <= {w_sum, r_acc[XLEN-1:1]};
            else if (!w_diff[XLEN])
                r_acc <= {w_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
            else
                r_acc <= {r_acc[2*XLEN-2:0], 1'b0};
        end
    end

    assign o_last = (r_count == CW'(XLEN-1));

    assign w_prod = r_neg ? -r_acc : r_acc;
    assign w_dres = w_rem ? r_acc[2*XLEN-1:XLEN] : r_acc[XLEN-1:0];

    always_comb begin
        o_result = r_neg ? -w_dres : w_dres;
        if (w_mul)
            o_result = (r_op == ALU_MUL)
                ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
    end

endmodule

// File: rtl/alu_mdu.sv
// Registered, handshaked integer execute unit: single-cycle base ALU
// plus an iterative multiply/divide path sequenced by a small FSM.
module alu_mdu
    import alu_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter bit MDU_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);
    localparam int SW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    state_e          r_state;
    state_e          w_state_nxt;
    logic            r_out_valid;
    logic [XLEN-1:0] r_result;

    alu_op_e         w_op;
    logic [SW-1:0]   w_shamt;
    logic [XLEN-1:0] w_alu;
    logic [XLEN-1:0] w_imm;
    logic [XLEN-1:0] w_mdu_res;
    logic            w_is_mdu;
    logic            w_divz;
    logic            w_ovf;
    logic            w_fast;
    logic            w_iter;
    logic            w_accept;
    logic            w_start;
    logic            w_load_imm;
    logic            w_last;

    assign w_op    = alu_op_e'(op);
    assign w_shamt = src2[SW-1:0];

    always_comb begin
        w_alu = '0;
        unique case (w_op)
            ALU_ADD:  w_alu = src1 + src2;
            ALU_SUB:  w_alu = src1 - src2;
            ALU_SLL:  w_alu = src1 << w_shamt;
            ALU_SRL:  w_alu = src1 >> w_shamt;
            ALU_SRA:  w_alu = $unsigned($signed(src1) >>> w_shamt);
            ALU_XOR:  w_alu = src1 ^ src2;
            ALU_OR:   w_alu = src1 | src2;
            ALU_AND:  w_alu = src1 & src2;
            ALU_SLT,
            ALU_LT:   w_alu = {{(XLEN-1){1'b0}}, $signed(src1) < $signed(src2)};
            ALU_SLTU,
            ALU_LTU:  w_alu = {{(XLEN-1){1'b0}}, src1 < src2};
            ALU_GE:   w_alu = {{(XLEN-1){1'b0}}, $signed(src1) >= $signed(src2)};
            ALU_GEU:  w_alu = {{(XLEN-1){1'b0}}, src1 >= src2};
            ALU_EQ:   w_alu = {{(XLEN-1){1'b0}}, src1 == src2};
            ALU_NE:   w_alu = {{(XLEN-1){1'b0}}, src1 != src2};
            default:  w_alu = '0;
        endcase
    end

    assign w_is_mdu = is_mdu_op(w_op);
    assign w_divz   = (src2 == '0);
    assign w_ovf    = (src1 == MIN_INT) && (src2 == '1);
    // Divide-by-zero and signed overflow have closed-form answers; skip CALC.
    assign w_fast = ((w_op inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU}) && w_divz)
        || ((w_op inside {ALU_DIV, ALU_REM}) && w_ovf);
    assign w_iter = MDU_EN && w_is_mdu && !w_fast;

    always_comb begin
        w_imm = w_alu;
        if (w_is_mdu) begin
            w_imm = '0;
            if (MDU_EN && w_divz)
                w_imm = (w_op inside {ALU_REM, ALU_REMU}) ? src1 : '1;
            else if (MDU_EN && w_ovf && w_op == ALU_DIV)
                w_imm = MIN_INT;
        end
    end

    assign in_ready   = (r_state == IDLE) && (!r_out_valid || out_ready);
    assign w_accept   = in_valid && in_ready;
    assign w_start    = w_accept && w_iter;
    assign w_load_imm = w_accept && !w_iter;

    mdu_iter #(.XLEN(XLEN)) u_iter (
        .clk      (clk),
        .rst      (rst),
        .i_start  (w_start),
        .i_step   (r_state == CALC),
        .i_op     (w_op),
        .i_a      (src1),
        .i_b      (src2),
        .o_last   (w_last),
        .o_result (w_mdu_res)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (w_start) w_state_nxt = CALC;
            CALC:    if (w_last) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
        end else if (w_load_imm) begin
            r_out_valid <= 1'b1;
            r_result    <= w_imm;
        end else if (r_state == DONE) begin
            r_out_valid <= 1'b1;
            r_result    <= w_mdu_res;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign busy      = (r_state == CALC);

endmodule
